// File: rtl/spi_controller.sv
// SPI register-access master: one 16-bit frame {wr_rdn, addr field, data} per start,
// all four SPI modes, SCLK half-period of CLK_DIV clk cycles.
module spi_controller #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned REG_W   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              wr_rdn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic [REG_W-1:0]  rdata,
  output logic              busy,
  output logic              done,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned AFLD_W    = 7;
  localparam int unsigned FRAME_W   = 1 + AFLD_W + REG_W;
  localparam int unsigned NUM_EDGES = 32;
  localparam int unsigned EDGE_W    = 6;
  localparam int unsigned CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GUARD
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [EDGE_W-1:0]  r_edge;
  logic [FRAME_W-1:0] r_tx;
  logic [REG_W-1:0]   r_rx;
  logic [REG_W-1:0]   r_rdata;
  logic               r_cpha;
  logic               r_wr;
  logic               r_sclk;
  logic               r_cs_n;
  logic               r_mosi;
  logic               r_busy;
  logic               r_done;

  logic [FRAME_W-1:0] w_frame;
  logic [EDGE_W-1:0]  w_next_edge;
  logic               w_last_cnt;
  logic               w_edge_evt;
  logic               w_lead;
  logic               w_sample;
  logic               w_shift;

  // Outgoing frame built from the live inputs; captured only on accept.
  assign w_frame = {wr_rdn, AFLD_W'(addr), wr_rdn ? wdata : REG_W'(0)};

  // SCLK edge bookkeeping: edges are numbered 1..32, odd ones are leading.
  assign w_last_cnt  = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_next_edge = r_edge + EDGE_W'(1);
  assign w_edge_evt  = w_last_cnt &&
                       ((r_state == ST_SETUP) ||
                        ((r_state == ST_SHIFT) && (r_edge != EDGE_W'(NUM_EDGES))));
  assign w_lead      = w_next_edge[0];
  // CPHA=1 skips the shift on edge 1 because bit15 is already on MOSI from SETUP.
  assign w_sample    = r_cpha ? ~w_lead : w_lead;
  assign w_shift     = r_cpha ? (w_lead && (w_next_edge != EDGE_W'(1))) : ~w_lead;

  // Transaction FSM with registered bus and handshake outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_edge  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_cpha  <= 1'b0;
      r_wr    <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_edge_evt) begin
        r_sclk <= ~r_sclk;
        r_edge <= w_next_edge;
        if (w_sample) begin
          r_rx <= {r_rx[REG_W-2:0], spi_miso};
        end
        if (w_shift) begin
          r_mosi <= r_tx[FRAME_W-1];
          r_tx   <= {r_tx[FRAME_W-2:0], 1'b0};
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (ena && start) begin
            r_state <= ST_SETUP;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_cpha  <= mode[0];
            r_wr    <= wr_rdn;
            r_sclk  <= mode[1];
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_mosi  <= w_frame[FRAME_W-1];
            r_tx    <= {w_frame[FRAME_W-2:0], 1'b0};
            r_rx    <= '0;
          end
        end
        ST_SETUP: begin
          if (w_last_cnt) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (w_last_cnt) begin
            r_cnt <= '0;
            if (r_edge == EDGE_W'(NUM_EDGES)) begin
              r_state <= ST_HOLD;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (w_last_cnt) begin
            r_state <= ST_GUARD;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_mosi  <= 1'b0;
            if (!r_wr) begin
              r_rdata <= r_rx;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_GUARD: begin
          if (w_last_cnt) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata    = r_rdata;
  assign busy     = r_busy;
  assign done     = r_done;
  assign spi_cs_n = r_cs_n;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: SPI peripheral model with a register file, a cycle-level
// reference model of the bus timing, and directed transactions with literal expectations.
module tb_spi_controller;

  logic       clk;
  logic       rstb;
  logic       ena;
  logic [1:0] mode;
  logic       start;
  logic       wr_rdn;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;

  int checks;
  int failures;

  spi_controller #(.ADDR_W(4), .REG_W(8), .CLK_DIV(4)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .mode     (mode),
    .start    (start),
    .wr_rdn   (wr_rdn),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Peripheral: register file, samples MOSI / drives MISO per the requested mode.
  logic [7:0]  p_regs [16];
  logic        p_cpol;
  logic        p_cpha;
  logic [15:0] p_rx;
  logic [15:0] p_last_frame;
  int          p_edges;
  int          p_last_edges;
  int          p_nsamp;
  logic [7:0]  p_reply;
  logic        p_prev;
  logic        p_lead;
  int          p_j;

  initial begin
    spi_miso = 1'b0;
    p_edges  = 0;
    forever begin
      @(negedge spi_cs_n);
      #1;
      p_rx = '0; p_nsamp = 0; p_edges = 0; p_reply = '0;
      p_prev = spi_clk;
      spi_miso = 1'b0;
      while (spi_cs_n == 1'b0) begin
        @(spi_clk or spi_cs_n);
        if (spi_cs_n == 1'b1) break;
        if (spi_clk == p_prev) continue;
        p_prev = spi_clk;
        p_edges++;
        p_lead = (spi_clk != p_cpol);
        if (p_lead == !p_cpha) begin
          p_rx = {p_rx[14:0], spi_mosi};
          p_nsamp++;
          if (p_nsamp == 8) p_reply = p_rx[7] ? 8'h00 : p_regs[p_rx[3:0]];
        end else begin
          p_j = p_cpha ? (p_edges - 1) / 2 : p_edges / 2;
          spi_miso = (p_j >= 8 && p_j < 16) ? p_reply[15 - p_j] : 1'b0;
        end
      end
      spi_miso = 1'b0;
      p_last_frame = p_rx;
      p_last_edges = p_edges;
      if (p_edges == 32 && p_rx[15]) p_regs[p_rx[11:8]] = p_rx[7:0];
    end
  end

  // Reference model: accept time, latched fields, expected register file and rdata.
  int          cyc;
  int          m_acc;
  logic        m_act;
  logic        m_cpol;
  logic        m_cpha;
  logic        m_wr;
  logic [3:0]  m_addr;
  logic [7:0]  m_wdata;
  logic [15:0] m_frame;
  logic [7:0]  m_rdata;
  logic [7:0]  m_regs [16];

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_act   <= 1'b0;
      m_cpol  <= 1'b0;
      m_cpha  <= 1'b0;
      m_rdata <= 8'h00;
    end else begin
      cyc <= cyc + 1;
      if (m_act && (cyc + 1 - m_acc) == 136) begin
        if (m_wr) m_regs[m_addr] <= m_wdata;
        else      m_rdata <= m_regs[m_addr];
      end
      if ((!m_act || (cyc - m_acc) >= 140) && ena && start) begin
        m_act   <= 1'b1;
        m_acc   <= cyc + 1;
        m_cpol  <= mode[1];
        m_cpha  <= mode[0];
        m_wr    <= wr_rdn;
        m_addr  <= addr;
        m_wdata <= wdata;
        m_frame <= {wr_rdn, 3'b000, addr, wr_rdn ? wdata : 8'h00};
      end
    end
  end

  // Every-cycle comparison of the bus and handshake against the model.
  int   c_d;
  int   c_j;
  logic c_fr;
  logic c_sclk;

  always @(negedge clk) begin
    if (!rstb) begin
      chk("rst_cs_n",  32'(spi_cs_n), 32'(1));
      chk("rst_sclk",  32'(spi_clk),  32'(0));
      chk("rst_mosi",  32'(spi_mosi), 32'(0));
      chk("rst_busy",  32'(busy),     32'(0));
      chk("rst_done",  32'(done),     32'(0));
      chk("rst_rdata", 32'(rdata),    32'(0));
    end else begin
      c_d  = cyc - m_acc;
      c_fr = m_act && c_d >= 0 && c_d <= 135;
      chk("cs_n",  32'(spi_cs_n), 32'(!c_fr));
      chk("busy",  32'(busy),     32'(c_fr));
      chk("done",  32'(done),     32'(m_act && c_d == 136));
      chk("rdata", 32'(rdata),    32'(m_rdata));
      c_sclk = m_cpol;
      if (m_act && c_d >= 4 && c_d <= 131) c_sclk = m_cpol ^ 1'(((c_d - 4) / 4 + 1) % 2);
      chk("spi_clk", 32'(spi_clk), 32'(c_sclk));
      if (!m_act || c_d >= 140) begin
        chk("mosi_idle", 32'(spi_mosi), 32'(0));
      end else if (!m_cpha && c_d <= 127) begin
        chk("mosi_cpha0", 32'(spi_mosi), 32'(m_frame[15 - c_d / 8]));
      end else if (m_cpha && c_d <= 131) begin
        c_j = (c_d < 12) ? 0 : (c_d - 4) / 8;
        chk("mosi_cpha1", 32'(spi_mosi), 32'(m_frame[15 - c_j]));
      end
    end
  end

  // One transaction: request, optional extra start pulses n negedges later, count dones.
  task automatic run_txn(input logic wr, input logic [1:0] md, input logic [3:0] a,
                         input logic [7:0] wd, input int pulse1, input int pulse2,
                         output int lat, output int ndone);
    int t_acc;
    p_cpol = md[1];
    p_cpha = md[0];
    @(negedge clk);
    ena = 1'b1; start = 1'b1; wr_rdn = wr; mode = md; addr = a; wdata = wd;
    t_acc = cyc;
    lat   = -1;
    ndone = 0;
    for (int n = 1; n <= 160; n++) begin
      @(negedge clk);
      start = (n == pulse1 || n == pulse2);
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc - t_acc;
      end
    end
    start = 1'b0;
  endtask

  int lat;
  int nd;
  int cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; m_acc = 0;
    for (int i = 0; i < 16; i++) begin
      p_regs[i] = 8'h00;
      m_regs[i] = 8'h00;
    end
    p_regs[9] = 8'h3C;
    m_regs[9] = 8'h3C;
    p_cpol = 1'b0; p_cpha = 1'b0;
    ena = 1'b0; start = 1'b0; wr_rdn = 1'b0; mode = 2'b00; addr = 4'h0; wdata = 8'h00;
    rstb = 1'b1;
    #1 rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cs_n",  32'(spi_cs_n), 32'(1));
    chk("reset_sclk",  32'(spi_clk),  32'(0));
    chk("reset_busy",  32'(busy),     32'(0));
    chk("reset_rdata", 32'(rdata),    32'h00);
    @(negedge clk) rstb = 1'b1;

    // Write, mode 00, reg3 <= A5
    run_txn(1'b1, 2'b00, 4'h3, 8'hA5, -1, -1, lat, nd);
    chk("wr_latency",    32'(lat),          32'd137);
    chk("wr_frame",      32'(p_last_frame), 32'h83A5);
    chk("wr_edges",      32'(p_last_edges), 32'd32);
    chk("wr_periph_reg", 32'(p_regs[3]),    32'hA5);
    chk("wr_rdata_keep", 32'(rdata),        32'h00);

    // Read, mode 11, reg3
    run_txn(1'b0, 2'b11, 4'h3, 8'hFF, -1, -1, lat, nd);
    chk("rd11_frame",    32'(p_last_frame), 32'h0300);
    chk("rd11_rdata",    32'(rdata),        32'hA5);
    chk("rd11_idle_clk", 32'(spi_clk),      32'(1));
    chk("rd11_latency",  32'(lat),          32'd137);

    // Read status reg9 in mode 01
    run_txn(1'b0, 2'b01, 4'h9, 8'h00, -1, -1, lat, nd);
    chk("rd01_frame", 32'(p_last_frame), 32'h0900);
    chk("rd01_rdata", 32'(rdata),        32'h3C);

    // Read reg3 in mode 00 so the next mode-10 read must change rdata
    run_txn(1'b0, 2'b00, 4'h3, 8'h00, -1, -1, lat, nd);
    chk("rd00_rdata", 32'(rdata), 32'hA5);

    // Read status reg9 in mode 10
    run_txn(1'b0, 2'b10, 4'h9, 8'h00, -1, -1, lat, nd);
    chk("rd10_frame",    32'(p_last_frame), 32'h0900);
    chk("rd10_rdata",    32'(rdata),        32'h3C);
    chk("rd10_idle_clk", 32'(spi_clk),      32'(1));

    // Write with stray start pulses in SHIFT (d=49) and GUARD (d=137)
    run_txn(1'b1, 2'b00, 4'h5, 8'h5A, 50, 138, lat, nd);
    chk("ignore_ndone",  32'(nd),        32'd1);
    chk("ignore_reg",    32'(p_regs[5]), 32'h5A);
    chk("ignore_idle",   32'(spi_cs_n),  32'(1));
    chk("ignore_rdata",  32'(rdata),     32'h3C);

    // start held with ena=0: nothing happens
    @(negedge clk);
    ena = 1'b0; start = 1'b1; wr_rdn = 1'b1; addr = 4'h7; wdata = 8'h11;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!spi_cs_n || done || busy) cnt++;
    end
    start = 1'b0;
    chk("ena0_no_activity", 32'(cnt), 32'd0);

    // Reset at edge 10 of a write to reg6
    p_cpol = 1'b0; p_cpha = 1'b0;
    @(negedge clk);
    ena = 1'b1; start = 1'b1; wr_rdn = 1'b1; mode = 2'b00; addr = 4'h6; wdata = 8'h77;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 100 && p_edges < 10; i++) @(posedge clk);
    chk("abort_edge10_reached", 32'(p_edges >= 10), 32'(1));
    #2 rstb = 1'b0;
    #1;
    chk("abort_cs_n", 32'(spi_cs_n), 32'(1));
    chk("abort_busy", 32'(busy),     32'(0));
    repeat (2) @(negedge clk);
    chk("abort_rdata", 32'(rdata), 32'h00);
    rstb = 1'b1;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", 32'(cnt),       32'd0);
    chk("abort_no_wr",   32'(p_regs[6]), 32'h00);

    run_txn(1'b1, 2'b00, 4'h6, 8'h77, -1, -1, lat, nd);
    chk("post_wr_latency", 32'(lat),          32'd137);
    chk("post_wr_frame",   32'(p_last_frame), 32'h8677);
    chk("post_wr_reg",     32'(p_regs[6]),    32'h77);
    run_txn(1'b0, 2'b00, 4'h6, 8'h00, -1, -1, lat, nd);
    chk("post_rd_rdata",   32'(rdata),        32'h77);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
